fetch_stage: RTL and testbench

Instruction fetch stage for the pipelined core. It sits directly upstream of the synchronous-read instruction memory (`imem`). It owns the program counter and drives the memory address, and it pairs each returned word with its PC for the decode stage. It also handles decode back-pressure and execute-stage redirects (branch/jump), including squash of the wrong-path word.

---
 rtl/fetch_stage_pkg.sv | 12 +
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic {
    StBoot = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read imem and
// pairs each returned word with its PC, handling stall and redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_tgt;
  logic         misalign_q;
  logic [31:0]  count_q;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};

  // The address issued this cycle is exactly the PC of next cycle's word,
  // so one mux serves both imem_addr and pc_d.
  always_comb begin
    state_d = StRun;
    pc_d    = pc_q;
    if (rst) begin
      state_d = StBoot;
      pc_d    = RESET_PC;
    end else if (redirect_valid) begin
      pc_d = redirect_tgt;
    end else if (state_q == StBoot) begin
      pc_d = RESET_PC;
    end else if (!stall) begin
      pc_d = pc_q + 32'd4;
    end
  end

  assign imem_addr = pc_d;

  always_comb begin
    inst_valid = !rst && (state_q == StRun) && !redirect_valid;
    inst       = inst_valid ? imem_rd_data : NOP_INST;
    inst_pc    = rst ? RESET_PC : pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        misalign_q <= 1'b1;
      end
      if (inst_valid && !stall) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage against a behavioural imem and fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [64];

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  // Reference model state: PC of the word on the imem bus next cycle.
  bit          m_run = 1'b0;
  logic [31:0] m_pc  = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  bit          m_mis = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rd_data  (imem_rd_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .misalign_err  (misalign_err),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_rd_data <= mem[imem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, push the expected outputs, advance the model.
  task automatic drv(input bit r, input bit s, input bit rv, input logic [31:0] rpc);
    exp_t        e;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst            = r;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    tgt     = {rpc[31:2], 2'b00};
    e.valid = !r && m_run && !rv;
    e.inst  = e.valid ? mem[m_pc[7:2]] : NOP;
    e.pc    = r ? 32'd0 : m_pc;
    e.addr  = r ? 32'd0 : rv ? tgt : !m_run ? 32'd0 : s ? m_pc : m_pc + 32'd4;
    e.cnt   = m_cnt;
    e.mis   = m_mis;
    sb.push_back(e);
    if (r) begin
      m_run = 1'b0;
      m_pc  = 32'd0;
      m_cnt = 32'd0;
      m_mis = 1'b0;
    end else begin
      if (e.valid && !s) m_cnt = m_cnt + 32'd1;
      if (rv) begin
        m_pc  = tgt;
        m_run = 1'b1;
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else if (!m_run) begin
        m_pc  = 32'd0;
        m_run = 1'b1;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_valid", {31'd0, inst_valid}, {31'd0, e.valid});
      check("sb_inst", inst, e.inst);
      check("sb_pc", inst_pc, e.pc);
      check("sb_addr", imem_addr, e.addr);
      check("sb_count", fetch_count, e.cnt);
      check("sb_misalign", {31'd0, misalign_err}, {31'd0, e.mis});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {16'hc0de, 8'h00, 8'(i)};
    mem[0]  = 32'h000000b7;
    mem[1]  = 32'h00508093;
    mem[2]  = 32'h500001b7;
    mem[3]  = 32'h00106213;
    mem[6]  = 32'hfe20fee3;
    mem[12] = 32'hfe1ff06f;
    mem[63] = 32'h7fff0063;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    @(posedge clk);

    drv(1, 0, 0, 0);
    @(negedge clk);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", inst, NOP);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    drv(0, 0, 0, 0);
    @(negedge clk);
    check("boot_valid", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("first_inst", inst, 32'h000000b7);
    check("first_pc", inst_pc, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("second_inst", inst, 32'h00508093);
    check("second_pc", inst_pc, 32'd4);

    for (int k = 0; k < 3; k++) begin
      drv(0, 1, 0, 0);
      @(negedge clk);
      check("stall_inst", inst, 32'h500001b7);
      check("stall_pc", inst_pc, 32'd8);
      check("stall_addr", imem_addr, 32'd8);
    end
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("post_stall_pc", inst_pc, 32'd12);
    check("post_stall_inst", inst, 32'h00106213);
    check("post_stall_count", fetch_count, 32'd3);

    drv(0, 0, 1, 32'h18);
    @(negedge clk);
    check("redir_squash", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("redir_pc", inst_pc, 32'h18);
    check("redir_inst", inst, 32'hfe20fee3);

    drv(0, 0, 0, 0);
    drv(0, 0, 1, 32'h1a);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("misal_pc", inst_pc, 32'h18);
    check("misal_flag", {31'd0, misalign_err}, 32'd1);
    repeat (3) drv(0, 0, 0, 0);
    @(negedge clk);
    check("misal_sticky", {31'd0, misalign_err}, 32'd1);

    drv(0, 1, 1, 32'h30);
    @(negedge clk);
    check("stall_redir_squash", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("stall_redir_pc", inst_pc, 32'h30);
    check("stall_redir_inst", inst, 32'hfe1ff06f);

    drv(0, 0, 1, 32'hffff_fffc);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("wrap_top_pc", inst_pc, 32'hffff_fffc);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("wrap_pc", inst_pc, 32'd0);
    check("wrap_inst", inst, 32'h000000b7);

    drv(1, 1, 0, 0);
    drv(1, 1, 0, 0);
    @(negedge clk);
    check("midrst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_misalign", {31'd0, misalign_err}, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("reboot_valid", {31'd0, inst_valid}, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("reboot_inst", inst, 32'h000000b7);
    check("reboot_pc", inst_pc, 32'd0);
    drv(0, 0, 0, 0);
    @(negedge clk);
    check("reboot_inst2", inst, 32'h00508093);
    check("reboot_pc2", inst_pc, 32'd4);

    @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
